// File: rtl/mc_dp_pkg.sv
// mc_dp_pkg: shared definitions for the multi-cycle datapath.
//   - op codes and R-type funct codes
//   - instruction field bit positions
//   - FSM state enumeration
package mc_dp_pkg;

    // Major op codes, instr[15:14]
    localparam logic [1:0] OP_R    = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_LW   = 2'b10;
    localparam logic [1:0] OP_SW   = 2'b11;

    // R-type funct codes, instr[1:0]
    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_SUB = 2'b01;
    localparam logic [1:0] FN_SLL = 2'b10;
    localparam logic [1:0] FN_AND = 2'b11;

    // Instruction field positions (rd and imm8 overlap by design)
    localparam int unsigned OP_HI  = 15;
    localparam int unsigned OP_LO  = 14;
    localparam int unsigned RS_HI  = 13;
    localparam int unsigned RS_LO  = 11;
    localparam int unsigned RT_HI  = 10;
    localparam int unsigned RT_LO  = 8;
    localparam int unsigned RD_HI  = 7;
    localparam int unsigned RD_LO  = 5;
    localparam int unsigned IMM_HI = 7;
    localparam int unsigned IMM_LO = 0;
    localparam int unsigned SH_HI  = 4;
    localparam int unsigned SH_LO  = 2;
    localparam int unsigned FN_HI  = 1;
    localparam int unsigned FN_LO  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_t;

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: NREGS x DATA_W register file.
//   clk, rst_n           clock / async active-low reset (clears every register)
//   we, waddr, wdata     synchronous write port; writes to r0 are dropped
//   raddr_a / rdata_a    combinational read port A
//   raddr_b / rdata_b    combinational read port B
//   dbg_raddr/dbg_rdata  combinational debug read port
// All read ports return 0 for r0.
module mc_regfile
    import mc_dp_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [2:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [2:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 3'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a   = (raddr_a   == 3'd0) ? '0 : regs[raddr_a];
    assign rdata_b   = (raddr_b   == 3'd0) ? '0 : regs[raddr_b];
    assign dbg_rdata = (dbg_raddr == 3'd0) ? '0 : regs[dbg_raddr];

endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle datapath (register file, ALU, load/store unit).
//   clk, rst_n             clock / async active-low reset
//   instr_valid/instr      instruction handshake input (16-bit encoding)
//   instr_ready            high only while IDLE
//   dmem_req/we/addr/wdata data-memory request, held stable until ack/timeout
//   dmem_rdata, dmem_ack   load data and one-cycle completion strobe
//   done                   one-cycle retire pulse (asserted in the IDLE cycle that follows)
//   err                    sticky memory-timeout flag
//   dbg_raddr/dbg_rdata    combinational register debug read
// Sequence: IDLE -> DECODE -> EXEC -> WB, or EXEC -> MEM -> {WB | IDLE}.
module mc_datapath
    import mc_dp_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int NREGS       = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              done,
    output logic              err,
    input  logic [2:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] op_a_q, op_b_q, imm_q, result_q;
    logic [DATA_W-1:0] rf_a, rf_b, alu_y;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_d, err_set, mem_expired;

    logic [1:0] op, funct;
    logic [2:0] rs, rt, rd, shamt;
    logic [7:0] imm8;

    assign op    = instr_q[OP_HI:OP_LO];
    assign rs    = instr_q[RS_HI:RS_LO];
    assign rt    = instr_q[RT_HI:RT_LO];
    assign rd    = instr_q[RD_HI:RD_LO];
    assign imm8  = instr_q[IMM_HI:IMM_LO];
    assign shamt = instr_q[SH_HI:SH_LO];
    assign funct = instr_q[FN_HI:FN_LO];

    assign instr_ready = (state_q == ST_IDLE);
    assign mem_expired = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    mc_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (state_q == ST_WB),
        .waddr     ((op == OP_R) ? rd : rt),
        .wdata     (result_q),
        .raddr_a   (rs),
        .rdata_a   (rf_a),
        .raddr_b   (rt),
        .rdata_b   (rf_b),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata)
    );

    // addi, lw and sw all use the rs + sext(imm8) sum; that sum is also the memory address.
    always_comb begin
        alu_y = op_a_q + imm_q;
        if (op == OP_R) begin
            case (funct)
                FN_ADD:  alu_y = op_a_q + op_b_q;
                FN_SUB:  alu_y = op_a_q - op_b_q;
                FN_SLL:  alu_y = op_b_q << shamt;
                FN_AND:  alu_y = op_a_q & op_b_q;
                default: alu_y = op_a_q + op_b_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_set = 1'b0;
        case (state_q)
            ST_IDLE:   if (instr_valid) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = ((op == OP_LW) || (op == OP_SW)) ? ST_MEM : ST_WB;
            ST_MEM: begin
                // An ack arriving in the final allowed cycle wins over the timeout.
                if (dmem_ack) begin
                    if (dmem_we) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (mem_expired) begin
                    state_d = ST_IDLE;
                    err_set = 1'b1;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            imm_q      <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= done_d;
            if (err_set) begin
                err <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                    end
                end
                ST_DECODE: begin
                    op_a_q <= rf_a;
                    op_b_q <= rf_b;
                    imm_q  <= {{(DATA_W - 8){imm8[7]}}, imm8};
                end
                ST_EXEC: begin
                    result_q <= alu_y;
                    if ((op == OP_LW) || (op == OP_SW)) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= (op == OP_SW);
                        dmem_addr  <= alu_y;
                        dmem_wdata <= op_b_q;
                        cnt_q      <= '0;
                    end
                end
                ST_MEM: begin
                    if (dmem_ack || mem_expired) begin
                        dmem_req <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (dmem_ack && !dmem_we) begin
                        result_q <= dmem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: directed stimulus with a scoreboard queue; a monitor pops and
// checks each retirement (latency, memory transaction, destination register).
module tb_mc_datapath;

    localparam int TB_TIMEOUT = 15;

    typedef struct {
        int acc;
        int lat;
        bit chk_reg;
        int r;
        int v;
        bit chk_mem;
        int we;
        int addr;
        int wdata;
        int reqc;
    } exp_t;

    logic        clk, rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        done, err;
    logic [2:0]  dbg_raddr, mon_raddr, stim_raddr;
    logic [15:0] dbg_rdata;
    logic        mon_sel;

    int   n_tests, n_fail;
    int   cyc, accepts, exp_acc;
    exp_t sbq[$];
    exp_t mon_e;

    // memory responder state
    int          ack_delay, cur_req, last_req;
    logic [15:0] rdata_cfg, last_addr, last_wdata;
    logic        last_we, req_prev, req_ever, unstable;

    assign dbg_raddr = mon_sel ? mon_raddr : stim_raddr;

    mc_datapath #(
        .DATA_W      (16),
        .NREGS       (8),
        .MEM_TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack),
        .done        (done),
        .err         (err),
        .dbg_raddr   (dbg_raddr),
        .dbg_rdata   (dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (instr_valid && instr_ready) accepts <= accepts + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_reg(input int lat, input int r, input int v);
        exp_t e;
        e = '{acc: 0, lat: lat, chk_reg: 1'b1, r: r, v: v, chk_mem: 1'b0,
              we: 0, addr: 0, wdata: 0, reqc: 0};
        return e;
    endfunction

    function automatic exp_t mk_mem(input int lat, input bit is_ld, input int r, input int v,
                                    input int addr, input int wdata, input int reqc);
        exp_t e;
        e = '{acc: 0, lat: lat, chk_reg: is_ld, r: r, v: v, chk_mem: 1'b1,
              we: is_ld ? 0 : 1, addr: addr, wdata: wdata, reqc: reqc};
        return e;
    endfunction

    // Memory model: acks in the ack_delay-th cycle of a request (0 = never).
    always @(negedge clk) begin
        if (dmem_req) begin
            if (!req_prev) begin
                cur_req  = 0;
                unstable = 1'b0;
            end else if (dmem_addr !== last_addr || dmem_we !== last_we ||
                         dmem_wdata !== last_wdata) begin
                unstable = 1'b1;
            end
            cur_req++;
            last_req   = cur_req;
            last_addr  = dmem_addr;
            last_we    = dmem_we;
            last_wdata = dmem_wdata;
            req_ever   = 1'b1;
            dmem_ack   = (ack_delay != 0) && (cur_req == ack_delay);
            dmem_rdata = rdata_cfg;
        end else begin
            dmem_ack = 1'b0;
        end
        req_prev = dmem_req;
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no retirement");
            end else begin
                mon_e = sbq.pop_front();
                check("latency", cyc - mon_e.acc, mon_e.lat);
                if (mon_e.chk_mem) begin
                    check("mem_we", 32'(last_we), mon_e.we);
                    check("mem_addr", 32'(last_addr), mon_e.addr);
                    if (mon_e.we != 0) check("mem_wdata", 32'(last_wdata), mon_e.wdata);
                    check("req_cycles", last_req, mon_e.reqc);
                    check("req_stable", 32'(unstable), 0);
                end
                if (mon_e.chk_reg) begin
                    mon_raddr = 3'(mon_e.r);
                    mon_sel   = 1'b1;
                    #1;
                    check("dest_reg", 32'(dbg_rdata), mon_e.v);
                    mon_sel   = 1'b0;
                end
            end
        end
    end

    task automatic wait_ready();
        int i;
        @(negedge clk);
        for (i = 0; i < 100 && !instr_ready; i++) @(negedge clk);
        if (!instr_ready) check("ready_wait", 32'(instr_ready), 1);
    endtask

    task automatic issue(input logic [15:0] ins, input bit expect_done, input exp_t e);
        exp_t t;
        wait_ready();
        t       = e;
        t.acc   = cyc + 1;
        instr   = ins;
        instr_valid = 1'b1;
        exp_acc++;
        if (expect_done) sbq.push_back(t);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sbq.size() == 0 && instr_ready) return;
        end
        check("drain_timeout", sbq.size(), 0);
    endtask

    task automatic read_reg(input int r, input int v, input string name);
        stim_raddr = 3'(r);
        #1;
        check(name, 32'(dbg_rdata), v);
    endtask

    exp_t none;

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; accepts = 0; exp_acc = 0;
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
        ack_delay = 0; rdata_cfg = '0; cur_req = 0; last_req = 0;
        last_addr = '0; last_wdata = '0; last_we = 1'b0;
        req_prev = 1'b0; req_ever = 1'b0; unstable = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        stim_raddr = '0; mon_raddr = '0; mon_sel = 1'b0;
        none = mk_reg(0, 0, 0);

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(instr_ready), 1);
        check("rst_req", 32'(dmem_req), 0);
        check("rst_we", 32'(dmem_we), 0);
        check("rst_addr", 32'(dmem_addr), 0);
        check("rst_wdata", 32'(dmem_wdata), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        rst_n = 1'b1;

        // 1: addi r1,r0,5
        issue(16'h4105, 1'b1, mk_reg(3, 1, 5));
        wait_drain();
        check("t1_no_req", 32'(req_ever), 0);

        // 2: ALU ops, back-to-back accepts
        issue(16'h4203, 1'b1, mk_reg(3, 2, 3));          // addi r2,r0,3
        issue(16'h0A61, 1'b1, mk_reg(3, 3, 2));          // sub r3,r1,r2
        issue(16'h018A, 1'b1, mk_reg(3, 4, 20));         // sll r4,r1,2
        issue(16'h11A1, 1'b1, mk_reg(3, 5, 'hFFFE));     // sub r5,r2,r1
        issue(16'h2580, 1'b1, mk_reg(3, 4, 'h12));       // add r4,r4,r5
        issue(16'h2C63, 1'b1, mk_reg(3, 3, 'h12));       // and r3,r5,r4
        issue(16'h52FF, 1'b1, mk_reg(3, 2, 2));          // addi r2,r2,-1
        wait_drain();

        // 3: sw r1 -> [4], then lw r6 <- [4]
        ack_delay = 3;
        issue(16'hC104, 1'b1, mk_mem(5, 1'b0, 0, 0, 4, 5, 3));
        wait_drain();
        ack_delay = 2; rdata_cfg = 16'h1234;
        issue(16'h8604, 1'b1, mk_mem(5, 1'b1, 6, 'h1234, 4, 0, 2));
        wait_drain();

        // ack in the expiry cycle counts as ack; negative offset address
        ack_delay = TB_TIMEOUT; rdata_cfg = 16'hBEEF;
        issue(16'h85FE, 1'b1, mk_mem(3 + TB_TIMEOUT, 1'b1, 5, 'hBEEF, 'hFFFE, 0, TB_TIMEOUT));
        wait_drain();
        check("no_err_at_limit", 32'(err), 0);

        // 4: lw r6 with no ack -> timeout
        ack_delay = 0;
        issue(16'h8608, 1'b0, none);
        for (int i = 0; i < 40 && !err; i++) @(negedge clk);
        check("to_err", 32'(err), 1);
        check("to_req_cycles", last_req, TB_TIMEOUT);
        check("to_ready", 32'(instr_ready), 1);
        check("to_req_low", 32'(dmem_req), 0);
        read_reg(6, 'h1234, "to_dest_kept");

        // 5: r0 write suppressed; held valid accepted once
        issue(16'h4007, 1'b1, mk_reg(3, 0, 0));
        wait_drain();
        wait_ready();
        none.acc = cyc + 1;
        instr = 16'h7F01;                                // addi r7,r7,1
        instr_valid = 1'b1;
        exp_acc++;
        sbq.push_back('{acc: cyc + 1, lat: 3, chk_reg: 1'b1, r: 7, v: 1, chk_mem: 1'b0,
                        we: 0, addr: 0, wdata: 0, reqc: 0});
        @(negedge clk);
        instr = 16'h7F05;                                // ignored while busy
        @(negedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        wait_drain();
        check("accept_count", accepts, exp_acc);
        check("err_sticky", 32'(err), 1);

        // 6: reset in the middle of MEM
        issue(16'h8608, 1'b0, none);
        for (int i = 0; i < 20 && !dmem_req; i++) @(negedge clk);
        check("t6_in_mem", 32'(dmem_req), 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_req_drop", 32'(dmem_req), 0);
        check("t6_err_clr", 32'(err), 0);
        for (int r = 1; r < 8; r++) read_reg(r, 0, "t6_reg_clr");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_ready", 32'(instr_ready), 1);
        check("sb_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
